priority_latch_shifter: RTL and testbench
=========================================

Name: priority_latch_shifter

Overview:
- Sits directly downstream of the combinational priority byte selector.
- Registers the selector's 8-bit result and feeds it back as the selector's hold value, closing the "keep prior value" loop.
- On every change of the held byte, serialises it out over a 3-wire shift/latch interface (sclk/sdata/slatch) for an external shift-register chain.

Parameters:
- DATA_WIDTH, 8, width of held byte and serial frame payload.
- CLK_DIV, 2, clk cycles per sclk half-period; legal range 1..15.
- MSB_FIRST, 1, 1 = shift bit DATA_WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_next  input  DATA_WIDTH  selector output (candidate new value).
- load_en  input  1  capture data_next into data_held this cycle.
- force_send  input  1  request a frame even if the value is unchanged.
- data_held  output  DATA_WIDTH  registered value; drives the selector's hold input.
- sclk  output  1  serial clock.
- sdata  output  1  serial data; stable while sclk high.
- slatch  output  1  latch strobe after the last bit.
- busy  output  1  high while a frame is in progress.
- pending  output  1  a frame is owed but not yet started.

Behaviour:
- Reset: on rst=1 at an edge, all of the following clear next cycle: data_held=0, sclk=0, sdata=0, slatch=0, busy=0, pending=0, state=IDLE. Reset mid-frame aborts immediately; the partial frame is discarded and no slatch pulse is issued.
- Hold register: if load_en=1, data_held<=data_next; otherwise it holds. Latency is 1 cycle.
- Change detect: pending<=1 when load_en=1 and data_next!=data_held, or when force_send=1. Otherwise pending is only cleared at frame start.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - If pending=1: shadow<=data_held, bit_cnt<=0, div_cnt<=0, busy<=1, go to SHIFT_LO.
  - pending clears in the same cycle unless a new set condition occurs that cycle; set wins.
- SHIFT_LO:
  - sclk=0; sdata=shadow bit selected by bit_cnt and MSB_FIRST, updated on entry.
  - After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI:
  - sclk=1; sdata is held.
  - After CLK_DIV cycles: if bit_cnt=DATA_WIDTH-1, go to LATCH; else increment bit_cnt and go to SHIFT_LO.
- LATCH:
  - sclk=0, slatch=1 for CLK_DIV cycles, then slatch=0, busy=0, go to IDLE.
- Frame length: busy is high for exactly 2*CLK_DIV*DATA_WIDTH + CLK_DIV cycles. With defaults that is 34.
- Back-to-back frames: if pending is set again during a frame, exactly one IDLE cycle separates the frames.
- Coalescing: multiple changes during a frame produce one follow-up frame carrying the latest data_held.
- Shadow stability: shadow is frozen for the whole frame; data_held may change freely during a frame.
- No-op write: load_en with data_next equal to data_held does not set pending.
- Revert while pending: a value changed and then restored before frame start still sends a frame. The compare is against data_held, not against the last sent value.
- Counter widths: div_cnt is 4 bits; bit_cnt is ceil(log2(DATA_WIDTH)) bits. No wrap occurs within legal parameter ranges.

Optional Feature:
- Macro: PRIORITY_LATCH_PARITY_EN.
- Defined:
  - One extra bit follows the payload: even parity (XOR of shadow), using the same LO/HI timing.
  - Frame length becomes 2*CLK_DIV*(DATA_WIDTH+1) + CLK_DIV cycles (38 with defaults).
  - slatch follows the parity bit.
- Undefined: no parity bit; timing is exactly as in Behaviour.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then inputs=0 for 50 cycles -> data_held=0, busy=0, sclk/sdata/slatch stay 0, no frame.
- Single update: load_en=1 with data_next=8'hA5 for 1 cycle -> data_held=A5 next cycle. Then:
  - pending=1, then busy for exactly 34 cycles;
  - the 8 sdata samples at sclk rising edges are 1,0,1,0,0,1,0,1;
  - slatch is high for 2 cycles after the last bit.
- No-op write: data_held=8'h3C, load_en=1 with data_next=8'h3C -> pending stays 0, no frame. Then force_send=1 for 1 cycle -> one frame carrying 3C.
- Coalesce mid-frame: during the A5 frame, load 8'h01 and then 8'hFF -> the current frame still shifts A5; exactly one IDLE cycle follows; the next frame shifts FF; no frame carries 01.
- Reset mid-frame: assert rst at bit 4 of a frame -> next cycle all outputs are 0, state=IDLE, no slatch pulse, and pending=0 afterwards.
- MSB_FIRST=0, CLK_DIV=1, data 8'h81 -> 10 if PRIORITY_LATCH_PARITY_EN is defined: bits 1,0,0,0,0,0,0,1,parity=0, busy=19 cycles; otherwise busy=17 cycles.

Source files
------------

// File: rtl/priority_latch_shifter_if.sv
// Bus between the priority byte selector and priority_latch_shifter: hold-loop
// signals plus the 3-wire shift/latch outputs for the external register chain.
interface priority_latch_shifter_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_next;
   logic                  load_en;
   logic                  force_send;
   logic [DATA_WIDTH-1:0] data_held;
   logic                  sclk;
   logic                  sdata;
   logic                  slatch;
   logic                  busy;
   logic                  pending;

   modport master (
      output data_next, load_en, force_send,
      input  data_held, sclk, sdata, slatch, busy, pending
   );

   modport slave (
      input  data_next, load_en, force_send,
      output data_held, sclk, sdata, slatch, busy, pending
   );
endinterface

// File: rtl/priority_latch_shifter.sv
// Holds the priority selector's result and serialises each new value over sclk/sdata/slatch.
// Define PRIORITY_LATCH_PARITY_EN to append an even-parity bit after the payload.
module priority_latch_shifter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_DIV    = 2,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input logic                     clk,
   input logic                     rst,
   priority_latch_shifter_if.slave bus
);

`ifdef PRIORITY_LATCH_PARITY_EN
   localparam int unsigned FRAME_BITS = DATA_WIDTH + 1;
   localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + 1);
`else
   localparam int unsigned FRAME_BITS = DATA_WIDTH;
   localparam int unsigned CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`endif
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StLatch} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] data_held_q;
   logic [DATA_WIDTH-1:0] shadow_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [3:0]            div_cnt_q;
   logic                  sclk_q;
   logic                  sdata_q;
   logic                  slatch_q;
   logic                  busy_q;
   logic                  pending_q;

   logic set_pending;
   logic div_done;

   // Frame bit idx of value v; idx DATA_WIDTH is the parity slot when enabled.
   function automatic logic sel_bit(input logic [DATA_WIDTH-1:0] v,
                                    input logic [CNT_W-1:0] idx);
      logic b;
      b = 1'b0;
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
         if (idx == CNT_W'(i)) b = MSB_FIRST ? v[DATA_WIDTH-1-i] : v[i];
      end
`ifdef PRIORITY_LATCH_PARITY_EN
      if (idx == CNT_W'(DATA_WIDTH)) b = ^v;
`endif
      return b;
   endfunction

   // Compare against the held value, not the last value sent.
   assign set_pending = (bus.load_en && (bus.data_next != data_held_q)) || bus.force_send;
   assign div_done    = (div_cnt_q == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         data_held_q <= '0;
         shadow_q    <= '0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
         sclk_q      <= 1'b0;
         sdata_q     <= 1'b0;
         slatch_q    <= 1'b0;
         busy_q      <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         if (bus.load_en) data_held_q <= bus.data_next;

         // A new set condition in the start cycle wins over the clear.
         if (set_pending) begin
            pending_q <= 1'b1;
         end else if ((state_q == StIdle) && pending_q) begin
            pending_q <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (pending_q) begin
                  shadow_q  <= data_held_q;
                  bit_cnt_q <= '0;
                  div_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  sclk_q    <= 1'b0;
                  sdata_q   <= sel_bit(data_held_q, '0);
                  state_q   <= StShiftLo;
               end
            end
            StShiftLo: begin
               if (div_done) begin
                  div_cnt_q <= '0;
                  sclk_q    <= 1'b1;
                  state_q   <= StShiftHi;
               end else begin
                  div_cnt_q <= div_cnt_q + 4'd1;
               end
            end
            StShiftHi: begin
               if (div_done) begin
                  div_cnt_q <= '0;
                  sclk_q    <= 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     sdata_q  <= 1'b0;
                     slatch_q <= 1'b1;
                     state_q  <= StLatch;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     sdata_q   <= sel_bit(shadow_q, bit_cnt_q + 1'b1);
                     state_q   <= StShiftLo;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 4'd1;
               end
            end
            StLatch: begin
               if (div_done) begin
                  div_cnt_q <= '0;
                  slatch_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  div_cnt_q <= div_cnt_q + 4'd1;
               end
            end
         endcase
      end
   end

   assign bus.data_held = data_held_q;
   assign bus.sclk      = sclk_q;
   assign bus.sdata     = sdata_q;
   assign bus.slatch    = slatch_q;
   assign bus.busy      = busy_q;
   assign bus.pending   = pending_q;

endmodule

// File: tb/tb_priority_latch_shifter.sv
// Directed bench for priority_latch_shifter: default instance (MSB first, CLK_DIV=2)
// and an LSB-first CLK_DIV=1 instance; frames are captured by a negedge monitor.
module tb_priority_latch_shifter;

`ifdef PRIORITY_LATCH_PARITY_EN
   localparam int NB     = 9;
   localparam int FRAME0 = 38;
   localparam int FRAME1 = 19;
`else
   localparam int NB     = 8;
   localparam int FRAME0 = 34;
   localparam int FRAME1 = 17;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   priority_latch_shifter_if #(.DATA_WIDTH(8)) bus0 ();
   priority_latch_shifter_if #(.DATA_WIDTH(8)) bus1 ();

   priority_latch_shifter #(.DATA_WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   priority_latch_shifter #(.DATA_WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor state, index 0 = dut0, 1 = dut1.
   int          cyc = 0;
   logic [15:0] f_bits  [2][16];
   int          f_n     [2][16];
   int          f_busy  [2][16];
   int          f_latch [2][16];
   int          f_start [2][16];
   int          f_end   [2][16];
   int          fcount    [2];
   int          lat_total [2];
   int          act       [2];
   logic [15:0] cur_bits  [2];
   int          cur_n [2], cur_busy [2], cur_latch [2], cur_start [2];
   bit          busy_prev [2], sclk_prev [2];
   logic        busy_w [2], sclk_w [2], sdata_w [2], slatch_w [2];

   assign busy_w[0]   = bus0.busy;
   assign sclk_w[0]   = bus0.sclk;
   assign sdata_w[0]  = bus0.sdata;
   assign slatch_w[0] = bus0.slatch;
   assign busy_w[1]   = bus1.busy;
   assign sclk_w[1]   = bus1.sclk;
   assign sdata_w[1]  = bus1.sdata;
   assign slatch_w[1] = bus1.slatch;

   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (slatch_w[d] === 1'b1) lat_total[d]++;
         if ((sclk_w[d] | sdata_w[d] | slatch_w[d] | busy_w[d]) === 1'b1) act[d]++;
         if (rst) begin
            busy_prev[d] = 1'b0;
            sclk_prev[d] = 1'b0;
         end else begin
            if (busy_w[d] && !busy_prev[d]) begin
               cur_bits[d]  = '0;
               cur_n[d]     = 0;
               cur_busy[d]  = 0;
               cur_latch[d] = 0;
               cur_start[d] = cyc;
            end
            if (busy_w[d]) begin
               cur_busy[d]++;
               if (sclk_w[d] && !sclk_prev[d]) begin
                  cur_bits[d] = {cur_bits[d][14:0], sdata_w[d]};
                  cur_n[d]++;
               end
               if (slatch_w[d]) cur_latch[d]++;
            end
            if (!busy_w[d] && busy_prev[d] && fcount[d] < 16) begin
               f_bits[d][fcount[d]]  = cur_bits[d];
               f_n[d][fcount[d]]     = cur_n[d];
               f_busy[d][fcount[d]]  = cur_busy[d];
               f_latch[d][fcount[d]] = cur_latch[d];
               f_start[d][fcount[d]] = cur_start[d];
               f_end[d][fcount[d]]   = cyc;
               fcount[d]++;
            end
            busy_prev[d] = busy_w[d];
            sclk_prev[d] = sclk_w[d];
         end
      end
   end

   function automatic logic [15:0] frame_exp(input logic [7:0] v, input bit msb);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[14:0], (msb ? v[7-i] : v[i])};
`ifdef PRIORITY_LATCH_PARITY_EN
      r = {r[14:0], ^v};
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load0(input logic [7:0] v);
      bus0.data_next = v;
      bus0.load_en   = 1'b1;
      tick();
      bus0.load_en   = 1'b0;
   endtask

   task automatic wait_frames(input int d, input int n, input int budget);
      int k;
      k = 0;
      while (fcount[d] < n && k < budget) begin
         tick();
         k++;
      end
      check("frame_count_reached", 32'(fcount[d] >= n), 32'd1);
   endtask

   task automatic check_frame(input string tag, input int d, input int i,
                              input logic [15:0] bits, input int blen, input int lat);
      check({tag, "_bits"}, 32'(f_bits[d][i]), 32'(bits));
      check({tag, "_nbits"}, f_n[d][i], NB);
      check({tag, "_busy"}, f_busy[d][i], blen);
      check({tag, "_latch"}, f_latch[d][i], lat);
   endtask

   int fc_before;
   int lat_before;

   initial begin
      bus0.data_next = '0; bus0.load_en = 1'b0; bus0.force_send = 1'b0;
      bus1.data_next = '0; bus1.load_en = 1'b0; bus1.force_send = 1'b0;

      // Reset then idle
      rst = 1'b1;
      tick_n(2);
      rst = 1'b0;
      check("rst_data_held", 32'(bus0.data_held), 32'h0);
      check("rst_busy", 32'(bus0.busy), 32'h0);
      check("rst_pending", 32'(bus0.pending), 32'h0);
      check("rst_serial", 32'({bus0.sclk, bus0.sdata, bus0.slatch}), 32'h0);
      check("rst_state", 32'(dut0.state_q), 32'h0);
      check("rst1_outputs", 32'({bus1.busy, bus1.pending, bus1.sclk, bus1.sdata, bus1.slatch}),
            32'h0);
      tick_n(50);
      check("idle_activity", act[0], 0);
      check("idle_frames", fcount[0], 0);
      check("idle_data_held", 32'(bus0.data_held), 32'h0);

      // Single update A5, with 01 then FF loaded mid-frame
      load0(8'hA5);
      check("a5_data_held", 32'(bus0.data_held), 32'hA5);
      check("a5_pending", 32'(bus0.pending), 32'h1);
      check("a5_busy_pre", 32'(bus0.busy), 32'h0);
      tick();
      check("a5_busy_start", 32'(bus0.busy), 32'h1);
      check("a5_pending_clr", 32'(bus0.pending), 32'h0);
      check("a5_first_bit", 32'({bus0.sclk, bus0.sdata}), 32'h1);
      tick_n(6);
      load0(8'h01);
      tick_n(3);
      load0(8'hFF);
      check("coal_data_held", 32'(bus0.data_held), 32'hFF);
      check("coal_pending", 32'(bus0.pending), 32'h1);
      wait_frames(0, 2, 200);
      check_frame("a5", 0, 0, frame_exp(8'hA5, 1'b1), FRAME0, 2);
      check_frame("ff", 0, 1, frame_exp(8'hFF, 1'b1), FRAME0, 2);
      check("coal_idle_gap", f_start[0][1] - f_end[0][0], 1);
      tick_n(50);
      check("coal_frames", fcount[0], 2);
      check("coal_pending_end", 32'(bus0.pending), 32'h0);

      // No-op write and force_send
      load0(8'h3C);
      wait_frames(0, 3, 200);
      check_frame("3c", 0, 2, frame_exp(8'h3C, 1'b1), FRAME0, 2);
      load0(8'h3C);
      check("noop_pending", 32'(bus0.pending), 32'h0);
      tick_n(60);
      check("noop_frames", fcount[0], 3);
      bus0.force_send = 1'b1;
      tick();
      bus0.force_send = 1'b0;
      check("force_pending", 32'(bus0.pending), 32'h1);
      tick();
      check("force_busy", 32'(bus0.busy), 32'h1);

      // Revert while pending: 11 then back to 3C during the forced frame
      tick_n(4);
      load0(8'h11);
      tick_n(2);
      load0(8'h3C);
      check("revert_pending", 32'(bus0.pending), 32'h1);
      wait_frames(0, 5, 300);
      check_frame("force3c", 0, 3, frame_exp(8'h3C, 1'b1), FRAME0, 2);
      check_frame("revert3c", 0, 4, frame_exp(8'h3C, 1'b1), FRAME0, 2);

      // Reset mid-frame at bit 4
      tick_n(10);
      load0(8'h96);
      tick();
      check("mid_busy", 32'(bus0.busy), 32'h1);
      tick_n(16);
      load0(8'h42);
      check("mid_bitcnt", 32'(dut0.bit_cnt_q), 32'h4);
      fc_before  = fcount[0];
      lat_before = lat_total[0];
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_outputs", 32'({bus0.busy, bus0.pending, bus0.sclk, bus0.sdata, bus0.slatch}),
            32'h0);
      check("mid_rst_data_held", 32'(bus0.data_held), 32'h0);
      check("mid_rst_state", 32'(dut0.state_q), 32'h0);
      tick_n(50);
      check("mid_rst_no_frame", fcount[0], fc_before);
      check("mid_rst_no_latch", lat_total[0], lat_before);
      check("mid_rst_pending", 32'(bus0.pending), 32'h0);

      // LSB first, CLK_DIV=1, data 81
      bus1.data_next = 8'h81;
      bus1.load_en   = 1'b1;
      tick();
      bus1.load_en   = 1'b0;
      check("lsb_pending", 32'(bus1.pending), 32'h1);
      wait_frames(1, 1, 100);
      check_frame("lsb81", 1, 0, frame_exp(8'h81, 1'b0), FRAME1, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
